// File: rtl/div_pkg.sv
// Shared op/state types and width-dependent constants for the divider front end.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_DRAIN = 5'b10000
  } div_ctrl_state_e;

  localparam int unsigned DIV_MAX_XLEN = 64;

  // Computed at the widest supported XLEN; callers truncate to their own width.
  function automatic logic [DIV_MAX_XLEN-1:0] div_most_neg(input int unsigned xlen);
    return {{(DIV_MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
  endfunction

  function automatic logic [DIV_MAX_XLEN-1:0] div_all_ones(input int unsigned xlen);
    return {DIV_MAX_XLEN{1'b1}} >> (DIV_MAX_XLEN - xlen);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational conditional two's-complement negate (abs of operands, sign restore of results).
module div_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (-i_val) : i_val;

endmodule

// File: rtl/div_ctrl.sv
// RV32M/RV64M DIV/DIVU/REM/REMU front end for an unsigned iterative divider core.
// Optional macro DIV_CTRL_PAIR_CACHE_EN: reuse the last core result for a matching operand pair.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy,
  output logic            dv_start,
  output logic [XLEN-1:0] dv_dividend,
  output logic [XLEN-1:0] dv_divisor,
  input  logic            dv_ready,
  input  logic            dv_done,
  input  logic [XLEN-1:0] dv_quotient,
  input  logic [XLEN-1:0] dv_remainder
);

  localparam logic [XLEN-1:0] L_MOST_NEG = XLEN'(div_most_neg(XLEN));
  localparam logic [XLEN-1:0] L_ALL_ONES = XLEN'(div_all_ones(XLEN));

  div_ctrl_state_e r_state, w_state_nxt;
  div_op_e         r_op;
  logic [XLEN-1:0] r_dividend, r_divisor, r_result;
  logic            r_sign_q, r_sign_r;

  logic            w_in_signed, w_in_rem, w_accept, w_done_ok, w_to_drain;
  logic            w_special, w_hit, w_r_rem;
  logic [XLEN-1:0] w_mag1, w_mag2, w_fix_q, w_fix_r, w_special_res, w_hit_res;

  assign w_in_signed = ~in_op[0];
  assign w_in_rem    = in_op[1];
  assign w_r_rem     = (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_accept    = (r_state == ST_IDLE) & in_valid & ~flush;
  assign w_done_ok   = (r_state == ST_WAIT) & dv_done & ~flush;
  // Once dv_start has gone out the core must run to completion, so flush drains.
  assign w_to_drain  = flush & ((r_state == ST_WAIT) | ((r_state == ST_ISSUE) & dv_ready));

  div_sign_fix #(.W(XLEN)) u_fix_rs1 (.i_val(in_rs1), .i_neg(w_in_signed & in_rs1[XLEN-1]), .o_val(w_mag1));
  div_sign_fix #(.W(XLEN)) u_fix_rs2 (.i_val(in_rs2), .i_neg(w_in_signed & in_rs2[XLEN-1]), .o_val(w_mag2));
  div_sign_fix #(.W(XLEN)) u_fix_q   (.i_val(dv_quotient),  .i_neg(r_sign_q), .o_val(w_fix_q));
  div_sign_fix #(.W(XLEN)) u_fix_r   (.i_val(dv_remainder), .i_neg(r_sign_r), .o_val(w_fix_r));

  always_comb begin
    w_special     = 1'b1;
    w_special_res = '0;
    if (in_rs2 == '0) begin
      w_special_res = w_in_rem ? in_rs1 : L_ALL_ONES;
    end else if (w_in_signed && (in_rs1 == L_MOST_NEG) && (in_rs2 == L_ALL_ONES)) begin
      w_special_res = w_in_rem ? '0 : in_rs1;
    end else if (in_rs1 == '0) begin
      w_special_res = '0;
    end else begin
      w_special = 1'b0;
    end
  end

`ifdef DIV_CTRL_PAIR_CACHE_EN
  logic            r_c_vld, r_c_signed;
  logic [XLEN-1:0] r_rs1, r_rs2, r_c_rs1, r_c_rs2, r_c_q, r_c_r;

  assign w_hit     = r_c_vld & (r_c_rs1 == in_rs1) & (r_c_rs2 == in_rs2) & (r_c_signed == w_in_signed);
  assign w_hit_res = w_in_rem ? r_c_r : r_c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_c_vld    <= 1'b0;
      r_c_signed <= 1'b0;
      r_c_rs1    <= '0;
      r_c_rs2    <= '0;
      r_c_q      <= '0;
      r_c_r      <= '0;
    end else begin
      if (w_accept) begin
        r_rs1 <= in_rs1;
        r_rs2 <= in_rs2;
      end
      if (w_to_drain) begin
        r_c_vld <= 1'b0;
      end else if (w_done_ok) begin
        r_c_vld    <= 1'b1;
        r_c_signed <= (r_op == OP_DIV) || (r_op == OP_REM);
        r_c_rs1    <= r_rs1;
        r_c_rs2    <= r_rs2;
        r_c_q      <= w_fix_q;
        r_c_r      <= w_fix_r;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = (w_special | w_hit) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        if (dv_ready)   w_state_nxt = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (flush)        w_state_nxt = ST_DRAIN;
        else if (dv_done) w_state_nxt = ST_DONE;
      end
      ST_DONE:  if (flush | out_ready) w_state_nxt = ST_IDLE;
      ST_DRAIN: if (dv_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_DIV;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= div_op_e'(in_op);
        r_dividend <= w_mag1;
        r_divisor  <= w_mag2;
        r_sign_q   <= w_in_signed & (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
        r_sign_r   <= w_in_signed & in_rs1[XLEN-1];
        if (w_special)  r_result <= w_special_res;
        else if (w_hit) r_result <= w_hit_res;
      end
      if (w_done_ok) r_result <= w_r_rem ? w_fix_r : w_fix_q;
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_result  = r_result;
  assign dv_start    = (r_state == ST_ISSUE) & dv_ready;
  assign dv_dividend = r_dividend;
  assign dv_divisor  = r_divisor;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural divider-core model and RISC-V reference results.
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam logic [1:0] B_DIV = 2'b00, B_DIVU = 2'b01, B_REM = 2'b10, B_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic        out_valid, out_ready, busy, dv_start, dv_ready, dv_done;
  logic [31:0] out_result, dv_dividend, dv_divisor, dv_quotient, dv_remainder;

  int unsigned checks = 0, errors = 0;
  int unsigned starts = 0;
  int unsigned core_lat_min = 2, core_lat_max = 7;
  bit          rdy_rand = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy), .dv_start(dv_start), .dv_dividend(dv_dividend),
    .dv_divisor(dv_divisor), .dv_ready(dv_ready), .dv_done(dv_done), .dv_quotient(dv_quotient),
    .dv_remainder(dv_remainder)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics written directly from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_rem, sgn;
    is_rem = op[1];
    sgn    = ~op[0];
    if (b == 32'h0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : a;
      return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Unsigned divider core: idle-ready, variable latency, one-cycle done pulse.
  initial begin
    dv_ready = 1'b1; dv_done = 1'b0; dv_quotient = '0; dv_remainder = '0;
    forever begin
      @(negedge clk);
      if (rst_n && dv_start) begin
        logic [31:0] a, b;
        int unsigned lat;
        a = dv_dividend;
        b = dv_divisor;
        starts++;
        check("core_divisor_nonzero", 64'(b != 32'h0), 64'd1);
        lat = $urandom_range(core_lat_max, core_lat_min);
        @(posedge clk); #1 dv_ready = 1'b0;
        repeat (lat) begin
          @(negedge clk);
          check("core_operands_held", {dv_dividend, dv_divisor}, {a, b});
          @(posedge clk);
        end
        #1;
        dv_done      = 1'b1;
        dv_quotient  = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
        dv_remainder = (b == 32'h0) ? a : a % b;
        @(posedge clk); #1 dv_done = 1'b0;
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1 dv_ready = 1'b1;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(3, 0) != 0);
    end
  end

  // Monitor: every result handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", out_result);
      end else begin
        check("result", 64'(out_result), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int unsigned s0);
    int unsigned n;
    n = 0;
    s0 = starts;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(ref_div(op, a, b));
    s0 = starts;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    logic empty;
    n = 0;
    @(negedge clk);
    while (!(in_ready && exp_q.size() == 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    empty = (exp_q.size() == 0);
    check(name, {in_ready, empty}, 2'b11);
  endtask

  task automatic special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s0;
    issue(op, a, b, 1'b1, s0);
    @(negedge clk);
    check("special_latency", 64'(out_valid), 64'd1);
    wait_idle("special_idle");
    check("special_no_start", 64'(starts), 64'(s0));
  endtask

  initial begin
    int unsigned s0, n;
    logic        seen;
    logic [31:0] a, b, pa, pb;
    logic [1:0]  op;

    #12;
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_dv_start",  64'(dv_start), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_operands",  {dv_dividend, dv_divisor}, 64'd0);
    #10 rst_n = 1'b1;

    issue(B_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1, s0);
    issue(B_REM,  32'hFFFF_FFF9, 32'd2, 1'b1, s0);
    issue(B_REMU, 32'd20, 32'd6, 1'b1, s0);
    wait_idle("basic_idle");

    special(B_DIVU, 32'd5, 32'd0);
    special(B_REM,  32'd5, 32'd0);
    special(B_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    special(B_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    special(B_DIV,  32'd0, 32'd13);

    // Result held under backpressure.
    out_ready = 1'b0;
    issue(B_DIV, 32'd100, 32'd7, 1'b1, s0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_result",   64'(out_result), 64'(ref_div(B_DIV, 32'd100, 32'd7)));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("hold_idle");
    check("hold_core_used", 64'(starts), 64'(s0 + 1));

    // Operand-pair reuse.
    issue(B_DIV, 32'd1000, 32'd33, 1'b1, s0);
    wait_idle("pair_div_idle");
    check("pair_div_core", 64'(starts), 64'(s0 + 1));
    issue(B_REM, 32'd1000, 32'd33, 1'b1, s0);
`ifdef DIV_CTRL_PAIR_CACHE_EN
    @(negedge clk);
    check("pair_rem_latency", 64'(out_valid), 64'd1);
    wait_idle("pair_rem_idle");
    check("pair_rem_core", 64'(starts), 64'(s0));
`else
    wait_idle("pair_rem_idle");
    check("pair_rem_core", 64'(starts), 64'(s0 + 1));
`endif

    // Flush while the core is running.
    core_lat_min = 6; core_lat_max = 6;
    issue(B_DIV, 32'd1000, 32'd3, 1'b0, s0);
    n = 0;
    @(negedge clk);
    while (starts == s0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("flush_start_seen", 64'(starts), 64'(s0 + 1));
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_drain", {busy, in_ready, out_valid}, 3'b100);
    seen = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      seen = seen | out_valid;
      n++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    check("flush_back_idle", 64'(in_ready), 64'd1);
    core_lat_min = 2; core_lat_max = 7;
    issue(B_DIV, 32'd9, 32'd3, 1'b1, s0);
    wait_idle("after_flush_idle");

    // Randomized traffic under random backpressure and core stalls.
    rdy_rand = 1'b1;
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(3, 0));
      if ($urandom_range(4, 0) == 0) begin
        a = pa; b = pb;
      end else begin
        case ($urandom_range(7, 0))
          0: a = 32'h0;
          1: a = 32'h8000_0000;
          2: a = 32'hFFFF_FFFF;
          3: a = 32'($urandom_range(50, 0));
          4: a = -32'($urandom_range(50, 1));
          default: a = $urandom();
        endcase
        case ($urandom_range(7, 0))
          0: b = 32'h0;
          1: b = 32'hFFFF_FFFF;
          2: b = 32'($urandom_range(9, 1));
          3: b = -32'($urandom_range(9, 1));
          4: b = 32'h8000_0000;
          default: b = $urandom();
        endcase
      end
      pa = a; pb = b;
      issue(op, a, b, 1'b1, s0);
    end
    rdy_rand = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-stage front end for RV32M/RV64M DIV/DIVU/REM/REMU; sits between issue and the unsigned iterative divider core.
- Accepts one op per valid/ready handshake and resolves RISC-V special cases locally: divide-by-zero, signed overflow and zero dividend.
- For all other ops, converts signed operands to magnitudes, drives the core's start/ready/quotient_vld interface, sign-corrects the result and holds it under out_valid/out_ready.
- Supports pipeline flush, including while the core is busy.

Parameters:
XLEN, 32, operand/result width; the core is instantiated with L_DIVN = L_DIVR = XLEN.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  op request
in_ready  out  1  high only in IDLE
in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
in_rs1  in  XLEN  dividend
in_rs2  in  XLEN  divisor
flush  in  1  discard in-flight op
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  XLEN  quotient or remainder, per op
busy  out  1  state != IDLE
dv_start  out  1  one-cycle start pulse to core
dv_dividend  out  XLEN  magnitude of rs1
dv_divisor  out  XLEN  magnitude of rs2
dv_ready  in  1  core idle
dv_done  in  1  core quotient_vld pulse
dv_quotient  in  XLEN  core quotient
dv_remainder  in  XLEN  core remainder

Behaviour:
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, dv_start 0, busy 0; all operand/sign registers 0.
- States:
  - IDLE: on in_valid & in_ready, latch op, magnitudes, sign_q = rs1[MSB]^rs2[MSB] (signed ops only), sign_r = rs1[MSB] (signed ops only). Go to DONE if special, else ISSUE.
  - ISSUE: wait for dv_ready; on the cycle dv_ready=1, assert dv_start for exactly 1 cycle, go to WAIT.
  - WAIT: on dv_done, capture and sign-correct the result, go to DONE.
  - DONE: out_valid=1, out_result stable; on out_ready go to IDLE.
  - DRAIN: wait for dv_done, discard the result, go to IDLE.
- Special cases (no core access; out_valid the cycle after the accept):
  - rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all-ones, op DIV/REM): DIV gives rs1; REM gives 0.
  - rs1==0 (rs2 nonzero): result 0.
- Magnitudes: signed op with negative operand uses two's complement negate; the most-negative value maps to 1<<(XLEN-1) unsigned, which is correct because the core is unsigned at width XLEN.
- Sign correction: quotient negated if sign_q; remainder negated if sign_r; unsigned ops pass the core result through unchanged.
- Latency (normal path): accept -> dv_start ≥1 cycle later -> core latency -> dv_done -> out_valid the next cycle.
- dv_dividend/dv_divisor: held stable from ISSUE until dv_done.
- flush:
  - In IDLE/ISSUE/DONE: go to IDLE next cycle, out_valid drops, no dv_start issued.
  - In WAIT: go to DRAIN, because the core cannot be aborted.
  - flush wins over in_valid, dv_done and out_ready in the same cycle.
  - flush in the dv_start cycle: go to DRAIN.
- Ignored inputs: in_valid outside IDLE; dv_done outside WAIT/DRAIN.
- Reset mid-operation returns to IDLE immediately; the core is reset on the same rst_n.
- Core error output is unused because divisor==0 never reaches the core.

Optional Feature:
DIV_CTRL_PAIR_CACHE_EN:
- Defined: stores {rs1, rs2, signedness, quotient, remainder} of the last completed core op.
- A new op with identical rs1, rs2 and signedness (e.g. DIV followed by REM) goes IDLE->DONE, with out_valid the cycle after accept and no dv_start.
- Cache invalidated on reset and on flush-to-DRAIN.
- Undefined: no cache registers; every non-special op goes through the core.

Decomposition:
- Package div_pkg: div_op_e (DIV/DIVU/REM/REMU) and div_ctrl_state_e (IDLE, ISSUE, WAIT, DONE, DRAIN, one-hot).
- Package also holds localparam helpers for the most-negative and all-ones constants, parameterised by XLEN.
- One sub-module: div_sign_fix (combinational abs/negate with a sign select), instantiated for the operands and the result.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> out_result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REMU 20,6 -> 2.
- DIVU rs1=5, rs2=0 -> 0xFFFFFFFF, out_valid 1 cycle after accept, dv_start never asserted; REM 5,0 -> 5.
- DIV 0x80000000, -1 -> 0x80000000; REM 0x80000000, -1 -> 0; no core access.
- DIV 100,7 with out_ready held low 5 cycles -> out_result 14 held stable, in_ready 0 throughout; accepted on out_ready.
- flush asserted 2 cycles after dv_start -> state DRAIN, out_valid never asserts, dv_done result discarded; next DIV 9,3 returns 3.
- With DIV_CTRL_PAIR_CACHE_EN: DIV 1000,33 -> 30, then REM 1000,33 -> 10 with out_valid 1 cycle after accept and no dv_start; without the macro, REM uses the core.
